// File: rtl/misr_compactor.sv
// misr_compactor
// Multiple-input signature register that sits behind the BIST pattern
// generator. Each valid response beat is folded into the signature. After
// NUM_PATTERNS beats the final signature is compared against GOLDEN and the
// result is reported through o_done / o_pass.
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       synchronous active-high reset, highest priority
//   i_start       begin a run (pulse or level; ignored while compacting)
//   i_abort       cancel a run in progress (only acts while compacting)
//   i_resp_valid  i_resp carries a beat this cycle
//   i_resp        circuit-under-test response word
//   o_busy        run in progress
//   o_done        run finished, held until the next start or reset
//   o_pass        final signature matched GOLDEN (valid while o_done=1)
//   o_signature   current MISR contents
//   o_count       beats absorbed in this run
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; responses ignored
// S_COMPACT | absorbing response beats, counting toward NUM_PATTERNS
// S_DONE    | run complete; signature, count and pass frozen

module misr_compactor #(
   parameter int             W            = 16,
   parameter logic [W-1:0]   POLY         = 16'h002D,
   parameter logic [W-1:0]   SEED         = '0,
   parameter int             NUM_PATTERNS = 1000,
   parameter int             CNT_W        = 16,
   parameter logic [W-1:0]   GOLDEN       = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_resp_valid,
   input  logic [W-1:0]     i_resp,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [W-1:0]     o_signature,
   output logic [CNT_W-1:0] o_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPACT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   // A zero-length run completes on the start edge itself. LAST_CNT is only
   // consulted while compacting, which a zero-length run never reaches.
   localparam bit              ZERO_RUN = (NUM_PATTERNS == 0);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

   state_t           r_state;
   logic [W-1:0]     r_sig;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   state_t           w_next_state;
   logic [W-1:0]     w_next_sig;
   logic [CNT_W-1:0] w_next_cnt;
   logic             w_next_pass;
   logic [W-1:0]     w_step;

   // Galois-style shift: the MSB shifted out selects the feedback taps,
   // then the response word is XORed across all bits.
   assign w_step = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0) ^ i_resp;

   always_comb begin
      w_next_state = r_state;
      w_next_sig   = r_sig;
      w_next_cnt   = r_cnt;
      w_next_pass  = r_pass;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_next_sig = SEED;
               w_next_cnt = '0;
               if (ZERO_RUN) begin
                  w_next_state = S_DONE;
                  w_next_pass  = (SEED == GOLDEN);
               end else begin
                  w_next_state = S_COMPACT;
                  w_next_pass  = 1'b0;
               end
            end
         end
         S_COMPACT: begin
            // abort wins over a coincident beat; partial results are kept
            if (i_abort) begin
               w_next_state = S_IDLE;
            end else if (i_resp_valid) begin
               w_next_sig = w_step;
               w_next_cnt = r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_next_state = S_DONE;
                  w_next_pass  = (w_step == GOLDEN);
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_sig   <= SEED;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_sig   <= w_next_sig;
         r_cnt   <= w_next_cnt;
         r_busy  <= (w_next_state == S_COMPACT);
         r_done  <= (w_next_state == S_DONE);
         r_pass  <= w_next_pass;
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_signature = r_sig;
   assign o_count     = r_cnt;

endmodule

// File: tb/tb_misr_compactor.sv
module tb_misr_compactor;

   localparam int          W      = 4;
   localparam logic [3:0]  POLY   = 4'h3;
   localparam logic [3:0]  SEED   = 4'h0;
   localparam int          NP     = 3;
   localparam int          CNT_W  = 8;
   localparam logic [3:0]  GOLDEN = 4'h4;
   // second instance: zero-length run
   localparam logic [3:0]  SEED_Z = 4'h5;

   logic             clk = 1'b0;
   logic             reset, start, abort, resp_valid;
   logic [W-1:0]     resp;
   logic             busy, done, pass;
   logic [W-1:0]     signature;
   logic [CNT_W-1:0] count;
   logic             z_busy, z_done, z_pass;
   logic [W-1:0]     z_signature;
   logic [CNT_W-1:0] z_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   misr_compactor #(
      .W(W), .POLY(POLY), .SEED(SEED), .NUM_PATTERNS(NP),
      .CNT_W(CNT_W), .GOLDEN(GOLDEN)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
      .i_resp_valid(resp_valid), .i_resp(resp),
      .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_signature(signature), .o_count(count)
   );

   misr_compactor #(
      .W(W), .POLY(POLY), .SEED(SEED_Z), .NUM_PATTERNS(0),
      .CNT_W(CNT_W), .GOLDEN(SEED_Z)
   ) dut_zero (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
      .i_resp_valid(resp_valid), .i_resp(resp),
      .o_busy(z_busy), .o_done(z_done), .o_pass(z_pass),
      .o_signature(z_signature), .o_count(z_count)
   );

   // ---------------- reference model (NUM_PATTERNS = 3 instance) ----------
   // signature treated as an integer: multiply by 2, reduce by the full
   // polynomial x^4 + POLY when it overflows, then add (XOR) the response.
   localparam int M_IDLE = 0, M_RUN = 1, M_FIN = 2;
   int m_phase = M_IDLE;
   int m_sig   = 0;
   int m_cnt   = 0;
   bit m_pass  = 0;

   function automatic int misr_ref(int s, int r);
      int t;
      t = s * 2;
      if (t >= 16) t = t ^ (16 + int'(POLY));
      return (t ^ r) % 16;
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_phase = M_IDLE; m_sig = int'(SEED); m_cnt = 0; m_pass = 0;
      end else if (m_phase == M_RUN) begin
         if (abort) m_phase = M_IDLE;
         else if (resp_valid) begin
            m_sig = misr_ref(m_sig, int'(resp));
            m_cnt = m_cnt + 1;
            if (m_cnt == NP) begin
               m_phase = M_FIN;
               m_pass  = (m_sig == int'(GOLDEN));
            end
         end
      end else if (start) begin
         m_phase = M_RUN; m_sig = int'(SEED); m_cnt = 0; m_pass = 0;
      end
   endtask

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(bit r, bit s, bit a, bit v, logic [3:0] d);
      reset = r; start = s; abort = a; resp_valid = v; resp = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk_out(string tag, int esig, int ecnt, bit ebusy, bit edone, bit epass);
      chk({tag, ".sig"},  int'(signature), esig);
      chk({tag, ".cnt"},  int'(count),     ecnt);
      chk({tag, ".busy"}, int'(busy),      int'(ebusy));
      chk({tag, ".done"}, int'(done),      int'(edone));
      chk({tag, ".pass"}, int'(pass),      int'(epass));
   endtask

   task automatic chk_model(string tag);
      chk_out(tag, m_sig, m_cnt, m_phase == M_RUN, m_phase == M_FIN,
              (m_phase == M_FIN) && m_pass);
   endtask

   typedef struct {
      bit         st, ab, v;
      logic [3:0] d;
      int         esig, ecnt;
      bit         ebusy, edone, epass;
   } vec_t;

   vec_t vt[$];

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; resp_valid = 1'b0; resp = '0;

      // start, beats 1,2,4 -> 1,0,4, pass
      vt.push_back('{1,0,0,4'h0, 0,0,1,0,0});
      vt.push_back('{0,0,1,4'h1, 1,1,1,0,0});
      vt.push_back('{0,0,1,4'h2, 0,2,1,0,0});
      vt.push_back('{0,0,1,4'h4, 4,3,0,1,1});
      vt.push_back('{0,0,1,4'hF, 4,3,0,1,1});   // DONE ignores beats
      // restart from DONE, beats 8,8,8 -> 8,B,D, fail
      vt.push_back('{1,0,0,4'h0, 0,0,1,0,0});
      vt.push_back('{0,0,1,4'h8, 8,1,1,0,0});
      vt.push_back('{0,0,1,4'h8, 11,2,1,0,0});
      vt.push_back('{0,0,1,4'h8, 13,3,0,1,0});
      vt.push_back('{0,1,0,4'h0, 13,3,0,1,0});  // abort ignored in DONE
      // start with coincident beat F: not absorbed
      vt.push_back('{1,0,1,4'hF, 0,0,1,0,0});
      vt.push_back('{0,0,1,4'h1, 1,1,1,0,0});
      vt.push_back('{0,1,1,4'h2, 1,1,0,0,0});  // abort beats beat
      vt.push_back('{0,0,1,4'h3, 1,1,0,0,0});  // IDLE ignores beats
      vt.push_back('{0,1,0,4'h0, 1,1,0,0,0});  // abort ignored in IDLE
      vt.push_back('{1,0,1,4'hF, 0,0,1,0,0});  // restart reloads SEED
      vt.push_back('{1,0,1,4'h1, 1,1,1,0,0});  // start ignored while busy

      apply(1, 0, 0, 0, 4'h0);
      chk_out("reset", 0, 0, 0, 0, 0);
      chk("reset.z_sig", int'(z_signature), int'(SEED_Z));
      chk("reset.z_done", int'(z_done), 0);

      foreach (vt[i]) begin
         apply(0, vt[i].st, vt[i].ab, vt[i].v, vt[i].d);
         chk_out($sformatf("vec%0d", i), vt[i].esig, vt[i].ecnt,
                 vt[i].ebusy, vt[i].edone, vt[i].epass);
      end

      // beats 1,2,4 with two idle cycles between, start pulsed in a gap
      apply(1, 0, 0, 0, 4'h0);
      apply(0, 1, 0, 0, 4'h0);
      apply(0, 0, 0, 1, 4'h1);
      apply(0, 1, 0, 0, 4'h7);
      chk_out("gap1a", 1, 1, 1, 0, 0);
      apply(0, 0, 0, 0, 4'h7);
      chk_out("gap1b", 1, 1, 1, 0, 0);
      apply(0, 0, 0, 1, 4'h2);
      apply(0, 0, 0, 0, 4'h9);
      apply(0, 1, 0, 0, 4'h9);
      chk_out("gap2", 0, 2, 1, 0, 0);
      apply(0, 0, 0, 1, 4'h4);
      chk_out("gap_end", 4, 3, 0, 1, 1);

      // reset while in DONE
      apply(1, 0, 0, 0, 4'h0);
      chk_out("rst_done", 0, 0, 0, 0, 0);

      // reset mid-run: no done pulse
      apply(0, 1, 0, 0, 4'h0);
      apply(0, 0, 0, 1, 4'h5);
      apply(1, 0, 0, 1, 4'h5);
      chk_out("rst_mid", 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 4'h0);
      chk_out("rst_mid2", 0, 0, 0, 0, 0);

      // zero-length run completes on the start edge
      apply(0, 1, 0, 1, 4'hA);
      chk("zero.done",  int'(z_done),      1);
      chk("zero.pass",  int'(z_pass),      1);
      chk("zero.busy",  int'(z_busy),      0);
      chk("zero.sig",   int'(z_signature), int'(SEED_Z));
      chk("zero.cnt",   int'(z_count),     0);

      // randomized run against the reference model
      apply(1, 0, 0, 0, 4'h0);
      for (int c = 0; c < 3000; c++) begin
         apply($urandom_range(199) == 0, $urandom_range(7) == 0,
               $urandom_range(15) == 0, $urandom_range(3) != 0,
               4'($urandom_range(15)));
         chk_model($sformatf("rnd%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
